// File: rtl/pgm_fifo_pkg.sv
// Shared sizing helpers for the FWFT read stage: buffer depth, pointer width
// and the legal RAM latency set.
package pgm_fifo_pkg;

  // One buffer slot per word that can be in flight, plus the head slot.
  function automatic int buf_depth(input int ram_latency);
    return ram_latency + 1;
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic bit lat_legal(input int ram_latency);
    return (ram_latency == 1) || (ram_latency == 2);
  endfunction

endpackage

// File: rtl/pgm_fifo_fwft_buf.sv
// Small circular buffer that catches RAM read data and presents the head word
// as a first-word-fall-through output.
module pgm_fifo_fwft_buf
  import pgm_fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2,
  parameter int PTR_W  = 1,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [CNT_W-1:0]  count,
  output logic              valid,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              pop_ok;

  assign valid  = (count != '0);
  assign pop_ok = pop & valid;
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop_ok)
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CNT_W'(wr_en) - CNT_W'(pop_ok);
    end
  end

  // The credit rule upstream guarantees this; a violation means lost data.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) count <= CNT_W'(DEPTH))
    else $error("fwft buffer overflow: count=%0d", count);

endmodule

// File: rtl/pgm_fifo_fwft_rd.sv
// FIFO read-side adapter: turns the controller's r_en / registered-RAM read
// port into a valid/ready stream, with combined occupancy reporting.
module pgm_fifo_fwft_rd
  import pgm_fifo_pkg::*;
#(
  parameter int c_DATA_WIDTH       = 8,
  parameter int c_RAM_LATENCY      = 1,
  parameter int c_RD_DEPTH_WIDTH   = 9,
  parameter int c_ALMOST_EMPTY_NUM = 4
) (
  input  logic                        rclk,
  input  logic                        rrst,
  input  logic                        fifo_rempty,
  output logic                        fifo_r_en,
  input  logic [c_DATA_WIDTH-1:0]     fifo_rdata,
  input  logic [c_RD_DEPTH_WIDTH:0]   fifo_rd_water_level,
  output logic [c_DATA_WIDTH-1:0]     m_tdata,
  output logic                        m_tvalid,
  input  logic                        m_tready,
  output logic [c_RD_DEPTH_WIDTH+1:0] m_level,
  output logic                        m_almost_empty
);

  localparam int  BUF_DEPTH = buf_depth(c_RAM_LATENCY);
  localparam int  PTR_W     = ptr_w(BUF_DEPTH);
  localparam int  CNT_W     = PTR_W + 1;
  localparam int  LVL_W     = c_RD_DEPTH_WIDTH + 2;
  localparam bit  LAT_OK    = lat_legal(c_RAM_LATENCY);

  logic [c_RAM_LATENCY-1:0] issue;
  logic [CNT_W-1:0]         inflight, stored;
  logic [CNT_W:0]           credit_used;
  logic                     pop, capture;

  assign pop     = m_tvalid & m_tready;
  assign capture = issue[c_RAM_LATENCY-1];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < c_RAM_LATENCY; i++) inflight = inflight + CNT_W'(issue[i]);
  end

  // A pop frees a slot this same cycle, so a full buffer can still issue and
  // sustain one word per clock. Reads into an empty controller are dropped by
  // it, so they must never be counted as credits.
  assign credit_used = {1'b0, inflight} + {1'b0, stored};
  assign fifo_r_en   = !fifo_rempty & ((credit_used < (CNT_W+1)'(BUF_DEPTH)) | pop);

  always_ff @(posedge rclk) begin
    if (rrst) begin
      issue <= '0;
    end else begin
      issue[0] <= fifo_r_en;
      for (int i = 1; i < c_RAM_LATENCY; i++) issue[i] <= issue[i-1];
    end
  end

  pgm_fifo_fwft_buf #(
    .DATA_W (c_DATA_WIDTH),
    .DEPTH  (BUF_DEPTH),
    .PTR_W  (PTR_W),
    .CNT_W  (CNT_W)
  ) u_buf (
    .clk     (rclk),
    .rst     (rrst),
    .wr_en   (capture),
    .wr_data (fifo_rdata),
    .pop     (pop),
    .count   (stored),
    .valid   (m_tvalid),
    .head    (m_tdata)
  );

  always_ff @(posedge rclk) begin
    if (rrst) m_level <= '0;
    else      m_level <= LVL_W'(fifo_rd_water_level) + LVL_W'(inflight) + LVL_W'(stored);
  end

  assign m_almost_empty = (m_level <= LVL_W'(c_ALMOST_EMPTY_NUM));

  a_lat_legal: assert property (@(posedge rclk) LAT_OK)
    else $error("c_RAM_LATENCY=%0d unsupported", c_RAM_LATENCY);

endmodule
